// File: rtl/irq_gateway.sv
// Interrupt gateway: latches source pulses as pending bits, masks them with an
// enable register and runs a claim/complete protocol over a simple register port.
module irq_gateway #(
  parameter int NSRC = 4,
  parameter int DW   = 32
) (
  input  logic            cpu_clk,
  input  logic            cpu_resetn,
  input  logic [NSRC-1:0] src_p,
  input  logic            reg_valid,
  input  logic            reg_wr,
  input  logic [3:0]      reg_addr,
  input  logic [DW-1:0]   reg_wdata,
  output logic            reg_ready,
  output logic [DW-1:0]   reg_rdata,
  output logic            irq_out
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t          state_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] in_service_q, in_service_d;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] overflow_q, overflow_d;
  logic            ready_q;
  logic [DW-1:0]   rdata_q;
  logic            irq_q;

  logic            accept;
  logic [NSRC-1:0] hit;
  logic [NSRC-1:0] claim_oh;
  logic [4:0]      claim_id;
  logic [NSRC-1:0] complete_oh;
  logic [DW-1:0]   rd_val;
  logic            unused_wdata;

  assign unused_wdata = ^reg_wdata;
  assign accept       = (state_q == S_IDLE) && reg_valid;
  assign hit          = pending_q & enable_q;

  always_comb begin
    claim_id    = '0;
    claim_oh    = '0;
    complete_oh = '0;
    // Descending scan so the lowest enabled pending source wins.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (hit[i]) begin
        claim_id = 5'(i + 1);
        claim_oh = NSRC'(1) << i;
      end
    end
    for (int i = 0; i < NSRC; i++) begin
      if (reg_wdata[4:0] == 5'(i + 1)) complete_oh[i] = 1'b1;
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_addr)
      4'h0:    rd_val = DW'(pending_q);
      4'h4:    rd_val = DW'(enable_q);
      4'h8:    rd_val = DW'(claim_id);
      4'hC:    rd_val = DW'(overflow_q);
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    pending_d    = pending_q | (src_p & ~pending_q & ~in_service_q);
    in_service_d = in_service_q;
    enable_d     = enable_q;
    overflow_d   = overflow_q;
    if (accept && !reg_wr && reg_addr == 4'h8) begin
      pending_d    = pending_d & ~claim_oh;
      in_service_d = in_service_q | claim_oh;
    end
    if (accept && reg_wr) begin
      case (reg_addr)
        4'h4:    enable_d     = reg_wdata[NSRC-1:0];
        4'h8:    in_service_d = in_service_q & ~complete_oh;
        4'hC:    overflow_d   = overflow_q & ~reg_wdata[NSRC-1:0];
        default: ;
      endcase
    end
    // New overflow events are applied after W1C so a simultaneous set wins.
    overflow_d = overflow_d | (src_p & (pending_q | in_service_q));
  end

  always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      in_service_q <= '0;
      enable_q     <= '0;
      overflow_q   <= '0;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      enable_q     <= enable_d;
      overflow_q   <= overflow_d;
      irq_q        <= |hit;
      case (state_q)
        S_IDLE: begin
          if (reg_valid) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            rdata_q <= reg_wr ? '0 : rd_val;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  assign reg_ready = ready_q;
  assign reg_rdata = rdata_q;
  assign irq_out   = irq_q;

endmodule

// File: tb/tb_irq_gateway.sv
// Bench for irq_gateway: directed register transactions with hand-computed
// expectations, plus a per-cycle comparison against a bit-level rule model.
module tb_irq_gateway;
  localparam int NSRC = 4;
  localparam int DW   = 32;

  logic            cpu_clk = 1'b0;
  logic            cpu_resetn = 1'b0;
  logic [NSRC-1:0] src_p = '0;
  logic            reg_valid = 1'b0;
  logic            reg_wr = 1'b0;
  logic [3:0]      reg_addr = '0;
  logic [DW-1:0]   reg_wdata = '0;
  logic            reg_ready;
  logic [DW-1:0]   reg_rdata;
  logic            irq_out;

  int tests_run = 0;
  int tests_failed = 0;

  irq_gateway #(.NSRC(NSRC), .DW(DW)) dut (
    .cpu_clk(cpu_clk), .cpu_resetn(cpu_resetn), .src_p(src_p),
    .reg_valid(reg_valid), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_ready(reg_ready), .reg_rdata(reg_rdata),
    .irq_out(irq_out)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Model state: one flag per source, plus the expected outputs after each edge.
  logic [NSRC-1:0] m_pend, m_en, m_ins, m_ovf;
  logic            m_busy, m_ready, m_irq;
  logic [DW-1:0]   m_rdata;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [NSRC-1:0] p, e, s, o;
    int k, kk;
    logic acc;
    if (!cpu_resetn) begin
      m_pend = '0; m_en = '0; m_ins = '0; m_ovf = '0;
      m_busy = 0; m_ready = 0; m_irq = 0; m_rdata = '0;
      return;
    end
    p = m_pend; e = m_en; s = m_ins; o = m_ovf;
    m_irq = 0;
    for (int i = 0; i < NSRC; i++) if (p[i] && e[i]) m_irq = 1;
    acc = !m_busy && reg_valid;
    k = 0;
    for (int i = 0; i < NSRC; i++) if (k == 0 && p[i] && e[i]) k = i + 1;
    m_rdata = '0;
    if (acc && !reg_wr) begin
      case (reg_addr)
        4'h0: m_rdata = DW'(p);
        4'h4: m_rdata = DW'(e);
        4'h8: begin
          m_rdata = DW'(k);
          if (k != 0) begin m_pend[k-1] = 0; m_ins[k-1] = 1; end
        end
        4'hC: m_rdata = DW'(o);
        default: m_rdata = '0;
      endcase
    end
    if (acc && reg_wr) begin
      case (reg_addr)
        4'h4: m_en = reg_wdata[NSRC-1:0];
        4'h8: begin
          kk = int'(reg_wdata[4:0]);
          if (kk >= 1 && kk <= NSRC && s[kk-1]) m_ins[kk-1] = 0;
        end
        4'hC: for (int i = 0; i < NSRC; i++) if (reg_wdata[i]) m_ovf[i] = 0;
        default: ;
      endcase
    end
    for (int i = 0; i < NSRC; i++) begin
      if (src_p[i]) begin
        if (p[i] || s[i]) m_ovf[i] = 1;
        else m_pend[i] = 1;
      end
    end
    m_ready = acc;
    m_busy  = acc;
  endtask

  initial begin
    forever begin
      @(posedge cpu_clk or negedge cpu_resetn);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge cpu_clk);
      check("cyc_ready", DW'(reg_ready), DW'(m_ready));
      check("cyc_irq", DW'(irq_out), DW'(m_irq));
      if (m_ready) check("cyc_rdata", reg_rdata, m_rdata);
    end
  end

  task automatic reg_xfer(input logic wr, input logic [3:0] addr, input logic [DW-1:0] wd,
                          input logic [NSRC-1:0] src, output logic [DW-1:0] rd);
    logic got;
    @(posedge cpu_clk); #2;
    reg_valid = 1; reg_wr = wr; reg_addr = addr; reg_wdata = wd; src_p = src;
    rd = '0; got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge cpu_clk); #1;
      src_p = '0;
      if (reg_ready) begin got = 1; rd = reg_rdata; end
    end
    reg_valid = 0;
    if (!got) check("ready_timeout", 0, 1);
    $display("[TB] %s addr=0x%0h wdata=0x%0h src=0x%0h rdata=0x%0h",
             wr ? "WR" : "RD", addr, wd, src, rd);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] addr, input logic [DW-1:0] exp);
    logic [DW-1:0] d;
    reg_xfer(0, addr, '0, '0, d);
    check(name, d, exp);
  endtask

  task automatic wr_reg(input logic [3:0] addr, input logic [DW-1:0] wd);
    logic [DW-1:0] d;
    reg_xfer(1, addr, wd, '0, d);
  endtask

  task automatic pulse(input logic [NSRC-1:0] v);
    @(posedge cpu_clk); #2;
    src_p = v;
    @(posedge cpu_clk); #1;
    src_p = '0;
  endtask

  initial begin
    logic [DW-1:0] d;
    repeat (3) @(posedge cpu_clk);
    #1;
    check("rst_ready", DW'(reg_ready), 0);
    check("rst_irq", DW'(irq_out), 0);
    check("rst_rdata", reg_rdata, 0);
    #1 cpu_resetn = 1;

    // Enable after pending; irq follows one edge after the enable update.
    pulse(4'b0100);
    wr_reg(4'h4, 32'h4);
    check("t1_irq_lat0", DW'(irq_out), 0);
    @(posedge cpu_clk); #1;
    check("t1_irq_lat1", DW'(irq_out), 1);
    rd_chk("t1_pending", 4'h0, 32'h4);

    rd_chk("t2_claim", 4'h8, 32'd3);
    rd_chk("t2_pending", 4'h0, 32'h0);
    check("t2_irq_low", DW'(irq_out), 0);
    pulse(4'b0100);
    rd_chk("t2_overflow", 4'hC, 32'h4);
    rd_chk("t2_pending2", 4'h0, 32'h0);
    wr_reg(4'h8, 32'd3);
    pulse(4'b0100);
    rd_chk("t2_pending3", 4'h0, 32'h4);
    wr_reg(4'hC, 32'hF);
    rd_chk("t2_ovf_clr", 4'hC, 32'h0);

    pulse(4'b1011);
    rd_chk("t3_pending", 4'h0, 32'hF);
    wr_reg(4'h4, 32'hA);
    rd_chk("t3_claim_a", 4'h8, 32'd2);
    rd_chk("t3_claim_b", 4'h8, 32'd4);
    rd_chk("t3_claim_c", 4'h8, 32'd0);
    rd_chk("t3_claim_d", 4'h8, 32'd0);
    wr_reg(4'h8, 32'd7);
    wr_reg(4'h8, 32'd0);
    wr_reg(4'h8, 32'd2);
    wr_reg(4'h8, 32'd2);
    pulse(4'b1010);
    rd_chk("t3_pending2", 4'h0, 32'h7);
    rd_chk("t3_overflow", 4'hC, 32'h8);
    wr_reg(4'h8, 32'd4);
    wr_reg(4'hC, 32'hF);

    wr_reg(4'h4, 32'h1);
    reg_xfer(0, 4'h8, '0, 4'b0001, d);
    check("t4_claim", d, 32'd1);
    rd_chk("t4_overflow", 4'hC, 32'h1);
    rd_chk("t4_pending", 4'h0, 32'h6);

    reg_xfer(1, 4'hC, 32'h1, 4'b0001, d);
    rd_chk("t5_set_wins", 4'hC, 32'h1);
    wr_reg(4'hC, 32'h1);
    rd_chk("t5_cleared", 4'hC, 32'h0);

    rd_chk("unmapped_rd", 4'h2, 32'h0);
    wr_reg(4'h6, 32'hF);
    rd_chk("unmapped_wr", 4'h4, 32'h1);

    wr_reg(4'h4, 32'h6);
    @(posedge cpu_clk); #1;
    check("t6_irq_pre", DW'(irq_out), 1);
    @(posedge cpu_clk); #2;
    reg_valid = 1; reg_wr = 0; reg_addr = 4'h0;
    @(posedge cpu_clk); #1;
    check("t6_in_resp", DW'(reg_ready), 1);
    #1 cpu_resetn = 0;
    #1;
    check("t6_ready_drop", DW'(reg_ready), 0);
    check("t6_irq_drop", DW'(irq_out), 0);
    reg_valid = 0;
    @(posedge cpu_clk); #2 cpu_resetn = 1;
    rd_chk("t6_pending", 4'h0, 32'h0);
    rd_chk("t6_enable", 4'h4, 32'h0);
    rd_chk("t6_claim", 4'h8, 32'h0);
    rd_chk("t6_overflow", 4'hC, 32'h0);

    @(posedge cpu_clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
